phase_win_cache: RTL and testbench
==================================

Name: phase_win_cache

Overview:
- Double-buffered row cache that feeds the phase-match core's window read port.
- Accepts one row of reference absolute-phase samples (ROW_SIZE samples, BEAT_SIZE per beat) on a valid/ready stream into the free bank.
- Serves WIN_SIZE-wide windows from the completed bank at a fixed READ_LATENCY, indexed by window address.
- Ping-pong operation lets row N+1 load while row N is being matched.

Parameters:
- ROW_SIZE, 1280: samples per row; must be a multiple of WIN_SIZE.
- WIN_SIZE, 128: samples per window; must be a multiple of BEAT_SIZE.
- BEAT_SIZE, 8: samples per input beat.
- DATA_WIDTH, 16: sample width, signed two's complement.
- READ_LATENCY, 2: cycles from cache_addr sample to cache_data valid; must be >= 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- s_tdata  in  BEAT_SIZE*DATA_WIDTH  beat; sample k in bits [k*DATA_WIDTH +: DATA_WIDTH], k=0 is the lowest row index
- s_tvalid  in  1  beat valid
- s_tlast  in  1  last beat of row
- s_tready  out  1  beat accept
- cache_addr  in  $clog2(ROW_SIZE/WIN_SIZE)  window index
- cache_data  out  WIN_SIZE*DATA_WIDTH  window; element i = row sample cache_addr*WIN_SIZE+i
- row_vld  out  1  a complete row is readable
- row_release  in  1  single-cycle pulse: consumer is finished with the current row
- len_err  out  1  one-cycle pulse on row length mismatch
- mono_err  out  1  sticky monotonicity error (see Optional Feature)

Behaviour:
- Reset: rst_n is synchronous, active-low; clock clk.
  - Reset values: s_tready=0, row_vld=0, len_err=0, mono_err=0, cache_data pipeline=0.
  - Internal state on reset: both banks free, wr_bank=0, rd_bank=0, beat_cnt=0.
  - Reset mid-fill or mid-read discards all rows; bank contents are don't-care.
- Derived constants: BEATS_PER_ROW=ROW_SIZE/BEAT_SIZE (160 by default); LAST_ADDR=ROW_SIZE/WIN_SIZE-1.
- Write FSM states: W_WAIT, W_FILL.
  - W_WAIT: s_tready=0. Go to W_FILL next cycle when bank wr_bank is free.
  - W_FILL: s_tready=1. Each beat (s_tvalid&s_tready) writes samples beat_cnt*BEAT_SIZE .. +BEAT_SIZE-1 of bank wr_bank, then beat_cnt++.
- Row completion:
  - On the beat where beat_cnt==BEATS_PER_ROW-1: mark the bank full, toggle wr_bank, clear beat_cnt, go to W_WAIT.
  - If s_tlast is not set on that beat, still complete the row and pulse len_err.
- Short row: s_tlast on a beat where beat_cnt<BEATS_PER_ROW-1.
  - Pulse len_err, discard the row (bank stays free, beat_cnt=0), stay in W_FILL.
- Read side:
  - row_vld = full[rd_bank].
  - row_release while row_vld: clear full[rd_bank] and toggle rd_bank, effective next cycle.
  - row_release while !row_vld: ignored.
- Simultaneous events:
  - Row completion and release in the same cycle both take effect.
  - With both banks full, s_tready stays 0 until a release frees a bank; W_WAIT re-enters W_FILL one cycle after the release.
- Read port:
  - cache_addr and rd_bank are sampled at cycle t; cache_data is valid at t+READ_LATENCY regardless of row_vld.
  - Fully pipelined: a new address is accepted every cycle.
  - cache_addr>LAST_ADDR returns all zeros.
  - A write to the other bank never disturbs read data.
- s_tready only drops on completion, reset, or both banks full; no combinational path from s_tvalid to s_tready.

Optional Feature:
- Macro: PHASE_WIN_CACHE_MONO_CHK_EN.
- Defined:
  - Checks that samples are non-decreasing (signed compare) within each beat and across consecutive beats of a row.
  - The first sample of a row is not compared with the previous row.
  - A violation sets mono_err; it stays set until reset.
  - The row is still stored.
- Undefined: mono_err tied 0; no compare logic is built.

Decomposition:
- Package pmp_cache_pkg:
  - write FSM state enum;
  - helper functions computing BEATS_PER_ROW, LAST_ADDR and the address width from the parameters.
- Sub-module win_cache_bank:
  - one bank, flop/LUTRAM storage;
  - beat-granular write port;
  - combinational window read by address.
- Top-level phase_win_cache:
  - instantiates two banks;
  - write FSM, bank flags, read-address/bank pipeline and output mux.

Test Plan:
- Ramp load: row of sample j=4*j in 160 beats (tlast on beat 159); after row_vld=1, drive cache_addr=3 -> 2 cycles later element0=1536, element127=2044.
- Ping-pong: send 3 rows back-to-back, no release -> rows 1,2 accepted, s_tready=0 during row 3; pulse row_release -> s_tready=1 two cycles later and reads now return row-2 data.
- Short row: tlast on beat 99 -> len_err one cycle, row_vld stays 0; next full row is accepted normally into the same bank.
- Missing tlast: 160 beats with no tlast -> len_err on beat 159, row_vld=1.
- Same-cycle release with completion of the other bank -> row_vld stays 1, rd_bank switches, reads return the new row; cache_addr=10 -> zeros.
- Reset asserted at beat 50 -> s_tready=0, row_vld=0; the subsequent row loads into bank 0. With PHASE_WIN_CACHE_MONO_CHK_EN, a sample 100 after 200 sets mono_err.

Source files
------------

// File: rtl/pmp_cache_pkg.sv
// Shared types and sizing helpers for the phase-match window cache.
package pmp_cache_pkg;

  typedef enum logic {
    W_WAIT = 1'b0,
    W_FILL = 1'b1
  } wstate_t;

  function automatic int beats_per_row(input int row_size, input int beat_size);
    return row_size / beat_size;
  endfunction

  function automatic int last_addr(input int row_size, input int win_size);
    return row_size / win_size - 1;
  endfunction

  // Never returns zero so a single-window row still gets a 1-bit address port.
  function automatic int addr_width(input int row_size, input int win_size);
    return (row_size / win_size > 1) ? $clog2(row_size / win_size) : 1;
  endfunction

endpackage

// File: rtl/win_cache_bank.sv
// One row bank: beat-granular write port, combinational window read by window index.
module win_cache_bank
  import pmp_cache_pkg::*;
#(
  parameter int ROW_SIZE   = 1280,
  parameter int WIN_SIZE   = 128,
  parameter int BEAT_SIZE  = 8,
  parameter int DATA_WIDTH = 16,
  parameter int BEAT_W     = 8,
  parameter int ADDR_W     = 4
) (
  input  logic                           clk,
  input  logic                           i_we,
  input  logic [BEAT_W-1:0]              i_beat_idx,
  input  logic [BEAT_SIZE*DATA_WIDTH-1:0] i_data,
  input  logic [ADDR_W-1:0]              i_addr,
  output logic [WIN_SIZE*DATA_WIDTH-1:0] o_win
);

  localparam int SW     = $clog2(ROW_SIZE);
  localparam int LAST_A = last_addr(ROW_SIZE, WIN_SIZE);

  logic [DATA_WIDTH-1:0] r_mem [ROW_SIZE];
  logic                  w_addr_ok;

  assign w_addr_ok = (int'(i_addr) <= LAST_A);

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int k = 0; k < BEAT_SIZE; k++) begin
        r_mem[SW'(i_beat_idx) * SW'(BEAT_SIZE) + SW'(k)] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Out-of-range window indices read as zero rather than aliasing into the row.
  for (genvar i = 0; i < WIN_SIZE; i++) begin : g_rd
    assign o_win[i*DATA_WIDTH +: DATA_WIDTH] =
      w_addr_ok ? r_mem[SW'(i_addr) * SW'(WIN_SIZE) + SW'(i)] : '0;
  end

endmodule

// File: rtl/phase_win_cache.sv
// Ping-pong row cache feeding the phase-match window port.
// Optional monotonicity checker enabled by defining PHASE_WIN_CACHE_MONO_CHK_EN.
module phase_win_cache
  import pmp_cache_pkg::*;
#(
  parameter int ROW_SIZE     = 1280,
  parameter int WIN_SIZE     = 128,
  parameter int BEAT_SIZE    = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [BEAT_SIZE*DATA_WIDTH-1:0]               s_tdata,
  input  logic                                          s_tvalid,
  input  logic                                          s_tlast,
  output logic                                          s_tready,
  input  logic [addr_width(ROW_SIZE, WIN_SIZE)-1:0]     cache_addr,
  output logic [WIN_SIZE*DATA_WIDTH-1:0]                cache_data,
  output logic                                          row_vld,
  input  logic                                          row_release,
  output logic                                          len_err,
  output logic                                          mono_err
);

  localparam int BPR = beats_per_row(ROW_SIZE, BEAT_SIZE);
  localparam int BW  = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int AW  = addr_width(ROW_SIZE, WIN_SIZE);
  localparam int WW  = WIN_SIZE * DATA_WIDTH;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BPR - 1);

  wstate_t         r_wstate;
  logic            r_wr_bank;
  logic            r_rd_bank;
  logic [1:0]      r_full;
  logic [BW-1:0]   r_beat_cnt;
  logic            r_len_err;
  logic [WW-1:0]   r_pipe [READ_LATENCY];

  logic            w_beat;
  logic            w_last_beat;
  logic            w_complete;
  logic            w_release;
  logic [1:0]      w_full_nxt;
  logic            w_we0;
  logic            w_we1;
  logic [WW-1:0]   w_win0;
  logic [WW-1:0]   w_win1;
  logic [WW-1:0]   w_win_sel;

  // Stream handshake: a beat transfers on a rising clk edge where s_tvalid and
  // s_tready are both high. s_tready decodes the write state register only, so it
  // never depends on s_tvalid; it falls after row completion, on reset, or while
  // the next bank to fill is still held by the consumer.
  assign s_tready    = (r_wstate == W_FILL);
  assign w_beat      = s_tvalid & s_tready;
  assign w_last_beat = (r_beat_cnt == LAST_BEAT);
  assign w_complete  = w_beat & w_last_beat;
  assign w_release   = row_release & r_full[r_rd_bank];
  assign row_vld     = r_full[r_rd_bank];
  assign len_err     = r_len_err;

  always_comb begin
    w_full_nxt = r_full;
    if (w_release)  w_full_nxt[r_rd_bank] = 1'b0;
    if (w_complete) w_full_nxt[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wstate   <= W_WAIT;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_full     <= 2'b00;
      r_beat_cnt <= '0;
      r_len_err  <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      r_full    <= w_full_nxt;
      if (w_release) r_rd_bank <= ~r_rd_bank;
      case (r_wstate)
        W_WAIT: begin
          if (!r_full[r_wr_bank]) r_wstate <= W_FILL;
        end
        W_FILL: begin
          if (w_beat) begin
            if (w_last_beat) begin
              // A full-length row is kept even without tlast; only the error is flagged.
              r_wstate   <= W_WAIT;
              r_wr_bank  <= ~r_wr_bank;
              r_beat_cnt <= '0;
              r_len_err  <= ~s_tlast;
            end else if (s_tlast) begin
              r_beat_cnt <= '0;
              r_len_err  <= 1'b1;
            end else begin
              r_beat_cnt <= r_beat_cnt + BW'(1);
            end
          end
        end
        default: r_wstate <= W_WAIT;
      endcase
    end
  end

  assign w_we0 = w_beat & ~r_wr_bank;
  assign w_we1 = w_beat & r_wr_bank;

  win_cache_bank #(
    .ROW_SIZE(ROW_SIZE), .WIN_SIZE(WIN_SIZE), .BEAT_SIZE(BEAT_SIZE),
    .DATA_WIDTH(DATA_WIDTH), .BEAT_W(BW), .ADDR_W(AW)
  ) u_bank0 (
    .clk(clk), .i_we(w_we0), .i_beat_idx(r_beat_cnt), .i_data(s_tdata),
    .i_addr(cache_addr), .o_win(w_win0)
  );

  win_cache_bank #(
    .ROW_SIZE(ROW_SIZE), .WIN_SIZE(WIN_SIZE), .BEAT_SIZE(BEAT_SIZE),
    .DATA_WIDTH(DATA_WIDTH), .BEAT_W(BW), .ADDR_W(AW)
  ) u_bank1 (
    .clk(clk), .i_we(w_we1), .i_beat_idx(r_beat_cnt), .i_data(s_tdata),
    .i_addr(cache_addr), .o_win(w_win1)
  );

  // The window is captured on the address cycle, so later writes cannot disturb it.
  assign w_win_sel = r_rd_bank ? w_win1 : w_win0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_win_sel;
      for (int i = 1; i < READ_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign cache_data = r_pipe[READ_LATENCY-1];

`ifdef PHASE_WIN_CACHE_MONO_CHK_EN
  logic signed [DATA_WIDTH-1:0] r_prev;
  logic                         r_mono_err;
  logic                         w_viol;

  // The first beat of a row is only checked internally, never against the prior row.
  always_comb begin
    w_viol = 1'b0;
    for (int k = 1; k < BEAT_SIZE; k++) begin
      if ($signed(s_tdata[k*DATA_WIDTH +: DATA_WIDTH]) <
          $signed(s_tdata[(k-1)*DATA_WIDTH +: DATA_WIDTH])) w_viol = 1'b1;
    end
    if ((r_beat_cnt != '0) && ($signed(s_tdata[DATA_WIDTH-1:0]) < r_prev)) w_viol = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev     <= '0;
      r_mono_err <= 1'b0;
    end else if (w_beat) begin
      r_prev <= s_tdata[BEAT_SIZE*DATA_WIDTH-1 -: DATA_WIDTH];
      if (w_viol) r_mono_err <= 1'b1;
    end
  end

  assign mono_err = r_mono_err;
`else
  assign mono_err = 1'b0;
`endif

endmodule

// File: tb/tb_phase_win_cache.sv
// Self-checking bench for phase_win_cache: scenario tasks plus a randomized
// sequence checked against a row-FIFO reference model.
module tb_phase_win_cache;

  localparam int ROW  = 1280;
  localparam int WIN  = 128;
  localparam int BEAT = 8;
  localparam int DW   = 16;
  localparam int RL   = 2;
  localparam int BPR  = ROW / BEAT;
  localparam int NWIN = ROW / WIN;
  localparam int AW   = 4;
`ifdef PHASE_WIN_CACHE_MONO_CHK_EN
  localparam bit MONO_EXP = 1'b1;
`else
  localparam bit MONO_EXP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [BEAT*DW-1:0] s_tdata = '0;
  logic               s_tvalid = 1'b0;
  logic               s_tlast = 1'b0;
  logic               s_tready;
  logic [AW-1:0]      cache_addr = '0;
  logic [WIN*DW-1:0]  cache_data;
  logic               row_vld;
  logic               row_release = 1'b0;
  logic               len_err;
  logic               mono_err;

  phase_win_cache #(
    .ROW_SIZE(ROW), .WIN_SIZE(WIN), .BEAT_SIZE(BEAT), .DATA_WIDTH(DW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .cache_addr(cache_addr), .cache_data(cache_data), .row_vld(row_vld),
    .row_release(row_release), .len_err(len_err), .mono_err(mono_err)
  );

  int total = 0;
  int bad = 0;

  // ---------------- scoreboard: rows readable, oldest first ----------------
  // Row descriptor {kink, base[15:0], step[15:0]}: sample j = base + step*j,
  // except sample 41 forced to 100 when kink is set.
  logic [32:0] exp_q[$];

  function automatic logic [DW-1:0] samp(input logic [32:0] d, input int j);
    int v;
    v = int'($signed(d[31:16])) + int'(d[15:0]) * j;
    if (d[32] && j == 41) v = 100;
    return v[DW-1:0];
  endfunction

  function automatic logic [WIN*DW-1:0] exp_win(input logic [32:0] d, input int a);
    logic [WIN*DW-1:0] w;
    w = '0;
    if (a < NWIN) begin
      for (int i = 0; i < WIN; i++) w[i*DW +: DW] = samp(d, a * WIN + i);
    end
    return w;
  endfunction

  function automatic logic [32:0] rand_desc();
    logic [15:0] b;
    logic [15:0] s;
    b = 16'(-int'($urandom_range(0, 3000)));
    s = 16'($urandom_range(1, 20));
    return {1'b0, b, s};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    row_release = 1'b0;
    cache_addr = '0;
    repeat (3) tick();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic check_vld(input string name);
    total++;
    if (row_vld !== (exp_q.size() > 0)) begin
      bad++;
      $display("FAIL %s row_vld: got %0b expected %0b", name, row_vld, exp_q.size() > 0);
    end
  endtask

  // Sends nbeats beats of row d; tlast on beat last_beat (-1 = never); optional
  // release pulse alongside the final beat. Checks len_err after every beat.
  task automatic send_row(input logic [32:0] d, input int nbeats, input int last_beat,
                          input bit rel_last, input string name);
    bit ok;
    bit exp_len;
    for (int b = 0; b < nbeats; b++) begin
      for (int k = 0; k < BEAT; k++) s_tdata[k*DW +: DW] = samp(d, b * BEAT + k);
      s_tvalid = 1'b1;
      s_tlast = (b == last_beat);
      row_release = rel_last && (b == nbeats - 1);
      ok = 1'b0;
      for (int t = 0; t < 400; t++) begin
        @(negedge clk);
        if (s_tready) begin
          ok = 1'b1;
          break;
        end
      end
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
      row_release = 1'b0;
      if (!ok) begin
        total++;
        bad++;
        $display("FAIL %s handshake: beat %0d not accepted within 400 cycles", name, b);
        return;
      end
      if (b == nbeats - 1 && nbeats == BPR) begin
        if (rel_last && exp_q.size() > 0) void'(exp_q.pop_front());
        exp_q.push_back(d);
      end
      exp_len = (nbeats == BPR && b == BPR - 1 && last_beat != b) ||
                (b == last_beat && b < BPR - 1);
      total++;
      if (len_err !== exp_len) begin
        bad++;
        $display("FAIL %s len_err beat %0d: got %0b expected %0b", name, b, len_err, exp_len);
      end
    end
    check_vld(name);
  endtask

  task automatic do_release(input string name);
    row_release = 1'b1;
    tick();
    row_release = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    check_vld(name);
  endtask

  // Pipelined reads, one random address per cycle, each checked RL cycles later.
  task automatic read_burst(input int n, input string name);
    logic [AW-1:0] a[$];
    logic [32:0]   d;
    logic [WIN*DW-1:0] e;
    if (exp_q.size() == 0) return;
    d = exp_q[0];
    for (int c = 0; c < n + RL; c++) begin
      if (c < n) begin
        a.push_back(AW'($urandom_range(0, 15)));
        cache_addr = a[c];
      end
      @(negedge clk);
      if (c >= RL) begin
        e = exp_win(d, int'(a[c-RL]));
        total++;
        if (cache_data !== e) begin
          bad++;
          for (int i = 0; i < WIN; i++) begin
            if (cache_data[i*DW +: DW] !== e[i*DW +: DW]) begin
              $display("FAIL %s read addr %0d elem %0d: got %0h expected %0h",
                       name, a[c-RL], i, cache_data[i*DW +: DW], e[i*DW +: DW]);
              break;
            end
          end
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL reset s_tready: got %0b expected 0", s_tready); end
    total++; if (row_vld !== 1'b0) begin bad++; $display("FAIL reset row_vld: got %0b expected 0", row_vld); end
    total++; if (len_err !== 1'b0) begin bad++; $display("FAIL reset len_err: got %0b expected 0", len_err); end
    total++; if (mono_err !== 1'b0) begin bad++; $display("FAIL reset mono_err: got %0b expected 0", mono_err); end
    total++; if (cache_data !== '0) begin bad++; $display("FAIL reset cache_data: got nonzero expected 0"); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_exit s_tready early: got %0b expected 0", s_tready); end
    tick();
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL reset_exit s_tready: got %0b expected 1", s_tready); end
  endtask

  task automatic test_ramp();
    do_reset();
    send_row({1'b0, 16'd0, 16'd4}, BPR, BPR - 1, 1'b0, "ramp");
    cache_addr = 4'd3;
    tick();
    cache_addr = 4'd0;
    tick();
    total++; if (cache_data[DW-1:0] !== 16'd1536) begin bad++; $display("FAIL ramp elem0: got %0d expected 1536", cache_data[DW-1:0]); end
    total++; if (cache_data[127*DW +: DW] !== 16'd2044) begin bad++; $display("FAIL ramp elem127: got %0d expected 2044", cache_data[127*DW +: DW]); end
    read_burst(20, "ramp_burst");
  endtask

  task automatic test_ping_pong();
    bit seen;
    logic [32:0] da, db, dc;
    da = rand_desc(); db = rand_desc(); dc = rand_desc();
    do_reset();
    send_row(da, BPR, BPR - 1, 1'b0, "pp_a");
    send_row(db, BPR, BPR - 1, 1'b0, "pp_b");
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (s_tready) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL pp_full s_tready: got 1 expected 0"); end
    read_burst(10, "pp_read_a");
    row_release = 1'b1;
    tick();
    row_release = 1'b0;
    void'(exp_q.pop_front());
    @(negedge clk);
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL pp_rel+1 s_tready: got %0b expected 0", s_tready); end
    @(posedge clk);
    #1;
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL pp_rel+2 s_tready: got %0b expected 1", s_tready); end
    check_vld("pp_after_rel");
    read_burst(10, "pp_read_b");
    send_row(dc, BPR, BPR - 1, 1'b0, "pp_c");
    read_burst(6, "pp_read_b2");
    do_release("pp_rel2");
    read_burst(10, "pp_read_c");
  endtask

  task automatic test_short_row();
    do_reset();
    send_row(rand_desc(), 100, 99, 1'b0, "short");
    tick();
    total++; if (len_err !== 1'b0) begin bad++; $display("FAIL short len_err width: got %0b expected 0", len_err); end
    check_vld("short_after");
    send_row(rand_desc(), BPR, BPR - 1, 1'b0, "short_next");
    read_burst(10, "short_read");
  endtask

  task automatic test_missing_tlast();
    do_reset();
    send_row(rand_desc(), BPR, -1, 1'b0, "no_tlast");
    read_burst(10, "no_tlast_read");
  endtask

  task automatic test_same_cycle();
    do_reset();
    send_row(rand_desc(), BPR, BPR - 1, 1'b0, "sc_x");
    send_row(rand_desc(), BPR, BPR - 1, 1'b1, "sc_y");
    read_burst(10, "sc_read_y");
    cache_addr = 4'd10;
    tick();
    cache_addr = 4'd2;
    tick();
    total++; if (cache_data !== '0) begin bad++; $display("FAIL sc_addr10: got nonzero expected 0"); end
    send_row(rand_desc(), BPR, BPR - 1, 1'b0, "sc_z");
    do_release("sc_rel");
    read_burst(10, "sc_read_z");
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_row(rand_desc(), BPR, BPR - 1, 1'b0, "rm_full");
    send_row(rand_desc(), 50, -1, 1'b0, "rm_part");
    rst_n = 1'b0;
    tick();
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL rm s_tready: got %0b expected 0", s_tready); end
    total++; if (row_vld !== 1'b0) begin bad++; $display("FAIL rm row_vld: got %0b expected 0", row_vld); end
    exp_q.delete();
    rst_n = 1'b1;
    send_row(rand_desc(), BPR, BPR - 1, 1'b0, "rm_next");
    read_burst(10, "rm_read");
  endtask

  task automatic test_random();
    int op;
    do_reset();
    for (int it = 0; it < 24; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0, 1: if (exp_q.size() < 2)
                send_row(rand_desc(), BPR, ($urandom_range(0, 4) == 0) ? -1 : BPR - 1, 1'b0, "rnd_row");
        2:    do_release("rnd_rel");
        3:    read_burst(8, "rnd_read");
        default: if (exp_q.size() < 2)
                send_row(rand_desc(), 0, 0, 1'b0, "rnd_none");
      endcase
      if (op == 4 && exp_q.size() < 2) begin
        op = $urandom_range(0, BPR - 2);
        send_row(rand_desc(), op + 1, op, 1'b0, "rnd_short");
      end
    end
    read_burst(8, "rnd_final");
  endtask

  task automatic test_mono();
    do_reset();
    send_row({1'b0, 16'd20000, 16'd3}, BPR, BPR - 1, 1'b0, "mono_r1");
    send_row({1'b0, 16'd0, 16'd5}, BPR, BPR - 1, 1'b0, "mono_r2");
    total++; if (mono_err !== 1'b0) begin bad++; $display("FAIL mono_clean: got %0b expected 0", mono_err); end
    do_release("mono_rel1");
    do_release("mono_rel2");
    send_row({1'b1, 16'd0, 16'd5}, BPR, BPR - 1, 1'b0, "mono_kink");
    repeat (3) tick();
    total++; if (mono_err !== MONO_EXP) begin bad++; $display("FAIL mono_kink: got %0b expected %0b", mono_err, MONO_EXP); end
    read_burst(10, "mono_read");
    do_reset();
    total++; if (mono_err !== 1'b0) begin bad++; $display("FAIL mono_reset: got %0b expected 0", mono_err); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ramp();
    test_ping_pong();
    test_short_row();
    test_missing_tlast();
    test_same_cycle();
    test_reset_mid();
    test_random();
    test_mono();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
